controlador_conversion: RTL and testbench

- Arbiter and sequencer that shares one iterative binary-to-BCD engine (double-dabble, one bit per cycle) between NUM_SOLICITANTES requesters, e.g. operand entry and result display.
- Grants round-robin, captures the winner's binary value, runs ANCHO_BIN shift/adjust iterations, then publishes packed BCD digits with a one-cycle completion flag and the winner's index.
- Sits between the arithmetic/input subsystems and the display driver.

---
 rtl/controlador_conversion_pkg.sv | 35 +++
 rtl/controlador_conversion_motor.sv | 54 +++++
 rtl/controlador_conversion.sv | 132 +++++++++++++
 tb/tb_controlador_conversion.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/controlador_conversion_pkg.sv
// +------------------------------------------------------------------+
// | paquete_conversion: shared types/constants for the BCD converter  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package paquete_conversion;

  localparam int ANCHO_BIN_DEF = 8;
  localparam int DIGITOS_DEF   = 3;

  typedef enum logic [1:0] {
    INACTIVO  = 2'd0,
    CONVIERTE = 2'd1,
    FIN       = 2'd2
  } estado_t;

  // Smallest digit count whose decimal range covers 2^ancho - 1.
  function automatic int digitos_minimos(input int ancho);
    longint maximo;
    longint limite;
    int     d;
    maximo = (longint'(1) << ancho) - 1;
    limite = 10;
    d      = 1;
    while (limite <= maximo) begin
      limite = limite * 10;
      d      = d + 1;
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_conversion_motor.sv
// +------------------------------------------------------------------+
// | motor_doble_dabble: one-bit-per-cycle binary to BCD engine       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module motor_doble_dabble #(
  parameter int ANCHO_BIN = 8,
  parameter int DIGITOS   = 3
) (
  input  logic                   reloj,
  input  logic                   reinicio,
  input  logic                   cargar,
  input  logic                   paso,
  input  logic [ANCHO_BIN-1:0]   valor,
  output logic                   hecho,
  output logic [4*DIGITOS-1:0]   bcd_siguiente
);

  localparam int ANCHO_CONT = $clog2(ANCHO_BIN) + 1;

  logic [4*DIGITOS-1:0] scratch;
  logic [4*DIGITOS-1:0] ajustado;
  logic [ANCHO_BIN-1:0] binario;
  logic [ANCHO_CONT-1:0] contador;

  for (genvar d = 0; d < DIGITOS; d++) begin : g_ajuste
    assign ajustado[4*d +: 4] = (scratch[4*d +: 4] > 4'd4) ? scratch[4*d +: 4] + 4'd3
                                                           : scratch[4*d +: 4];
  end

  // Result of the step about to happen; the top captures it on the final step.
  assign bcd_siguiente = {ajustado[4*DIGITOS-2:0], binario[ANCHO_BIN-1]};
  assign hecho         = (contador == ANCHO_CONT'(ANCHO_BIN - 1));

  always_ff @(posedge reloj or posedge reinicio) begin
    if (reinicio) begin
      scratch  <= '0;
      binario  <= '0;
      contador <= '0;
    end else if (cargar) begin
      scratch  <= '0;
      binario  <= valor;
      contador <= '0;
    end else if (paso) begin
      scratch  <= bcd_siguiente;
      binario  <= binario << 1;
      contador <= contador + ANCHO_CONT'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/controlador_conversion.sv
// +------------------------------------------------------------------+
// | controlador_conversion: round-robin arbiter sharing one BCD engine|
// | Optional macro CONVERSION_SIGNO_EN: two's complement inputs. Rev 1.0|
// +------------------------------------------------------------------+
`default_nettype none

module controlador_conversion
  import paquete_conversion::*;
#(
  parameter int ANCHO_BIN        = ANCHO_BIN_DEF,
  parameter int DIGITOS          = DIGITOS_DEF,
  parameter int NUM_SOLICITANTES = 2
) (
  input  logic                                  reloj,
  input  logic                                  reinicio,
  input  logic [NUM_SOLICITANTES-1:0]           solicitud,
  input  logic [NUM_SOLICITANTES*ANCHO_BIN-1:0] datoEntrada,
  output logic [NUM_SOLICITANTES-1:0]           concedido,
  output logic [4*DIGITOS-1:0]                  bcd,
  output logic [2:0]                            idResultado,
  output logic                                  banderaConvertida,
  output logic                                  signo
);

  estado_t              estado;
  logic [2:0]           ultimo;
  logic [2:0]           duenio;
  logic [2:0]           ganador;
  logic                 hay_solicitud;
  logic [3:0]           suma;
  logic [7:0]           sol_ext;
  logic [ANCHO_BIN-1:0] datos [8];
  logic [ANCHO_BIN-1:0] dato_sel;
  logic [ANCHO_BIN-1:0] magnitud;
  logic                 signo_entrada;
  logic                 signo_lat;
  logic                 cargar;
  logic                 hecho;
  logic [4*DIGITOS-1:0] bcd_sig;

  // Unused slots of the 8-entry view read as zero so the arbiter can use a fixed 3-bit index.
  assign sol_ext = 8'(solicitud);
  for (genvar k = 0; k < 8; k++) begin : g_desempaque
    if (k < NUM_SOLICITANTES) begin : g_activo
      assign datos[k] = datoEntrada[k*ANCHO_BIN +: ANCHO_BIN];
    end else begin : g_vacio
      assign datos[k] = '0;
    end
  end

  always_comb begin
    hay_solicitud = 1'b0;
    ganador       = '0;
    suma          = '0;
    for (int i = 1; i <= NUM_SOLICITANTES; i++) begin
      suma = {1'b0, ultimo} + 4'(i);
      if (suma >= 4'(NUM_SOLICITANTES)) suma = suma - 4'(NUM_SOLICITANTES);
      if (!hay_solicitud && sol_ext[suma[2:0]]) begin
        hay_solicitud = 1'b1;
        ganador       = suma[2:0];
      end
    end
  end

  assign dato_sel = datos[ganador];

`ifdef CONVERSION_SIGNO_EN
  assign signo_entrada = dato_sel[ANCHO_BIN-1];
  // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
  assign magnitud      = signo_entrada ? (~dato_sel + ANCHO_BIN'(1)) : dato_sel;
`else
  assign signo_entrada = 1'b0;
  assign magnitud      = dato_sel;
`endif

  assign cargar = (estado == INACTIVO) && hay_solicitud;

  motor_doble_dabble #(
    .ANCHO_BIN (ANCHO_BIN),
    .DIGITOS   (DIGITOS)
  ) u_motor (
    .reloj         (reloj),
    .reinicio      (reinicio),
    .cargar        (cargar),
    .paso          (estado == CONVIERTE),
    .valor         (magnitud),
    .hecho         (hecho),
    .bcd_siguiente (bcd_sig)
  );

  always_ff @(posedge reloj or posedge reinicio) begin
    if (reinicio) begin
      estado            <= INACTIVO;
      concedido         <= '0;
      bcd               <= '0;
      idResultado       <= '0;
      banderaConvertida <= 1'b0;
      signo             <= 1'b0;
      ultimo            <= 3'(NUM_SOLICITANTES - 1);
      duenio            <= '0;
      signo_lat         <= 1'b0;
    end else begin
      concedido         <= '0;
      banderaConvertida <= 1'b0;
      case (estado)
        INACTIVO: begin
          if (hay_solicitud) begin
            concedido <= NUM_SOLICITANTES'(1) << ganador;
            ultimo    <= ganador;
            duenio    <= ganador;
            signo_lat <= signo_entrada;
            estado    <= CONVIERTE;
          end
        end
        CONVIERTE: begin
          if (hecho) begin
            bcd               <= bcd_sig;
            idResultado       <= duenio;
            signo             <= signo_lat;
            banderaConvertida <= 1'b1;
            estado            <= FIN;
          end
        end
        FIN:     estado <= INACTIVO;
        default: estado <= INACTIVO;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_controlador_conversion.sv
// +------------------------------------------------------------------+
// | tb_controlador_conversion: randomized self-checking bench        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_controlador_conversion;

  localparam int ANCHO_BIN = 8;
  localparam int DIGITOS   = 3;
  localparam int NSOL      = 2;

  logic                      reloj = 1'b0;
  logic                      reinicio;
  logic [NSOL-1:0]           solicitud;
  logic [NSOL*ANCHO_BIN-1:0] datoEntrada;
  logic [NSOL-1:0]           concedido;
  logic [4*DIGITOS-1:0]      bcd;
  logic [2:0]                idResultado;
  logic                      banderaConvertida;
  logic                      signo;

  int checks = 0;
  int errors = 0;
  int ult;            // model of the round-robin pointer
  bit recien_fin;     // previous call returned on the completion cycle
  logic [11:0] ultimo_bcd;

  controlador_conversion #(
    .ANCHO_BIN        (ANCHO_BIN),
    .DIGITOS          (DIGITOS),
    .NUM_SOLICITANTES (NSOL)
  ) dut (
    .reloj             (reloj),
    .reinicio          (reinicio),
    .solicitud         (solicitud),
    .datoEntrada       (datoEntrada),
    .concedido         (concedido),
    .bcd               (bcd),
    .idResultado       (idResultado),
    .banderaConvertida (banderaConvertida),
    .signo             (signo)
  );

  always #5 reloj = ~reloj;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, esp);
    end
  endtask

  function automatic logic [11:0] bcd_ref(input int v);
    logic [11:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITOS; d++) begin
      r = r | (12'(x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic idle(input int n);
    solicitud = '0;
    repeat (n) begin
      @(negedge reloj);
      check("idle_no_grant", concedido, 0);
      check("idle_no_flag", banderaConvertida, 0);
    end
    recien_fin = 1'b0;
  endtask

  // Issues a request pattern and follows the winner through to completion.
  task automatic convertir(input logic [1:0] req, input logic [7:0] v0, input logic [7:0] v1);
    int   exp_k;
    int   espera;
    int   mag;
    logic s_esp;
    logic [7:0] v;
    exp_k = -1;
    for (int i = 1; i <= NSOL; i++) begin
      int c;
      c = (ult + i) % NSOL;
      if (exp_k < 0 && req[c]) exp_k = c;
    end
    solicitud   = req;
    datoEntrada = {v1, v0};
    espera = 0;
    do begin
      @(negedge reloj);
      espera++;
      if (espera == 1) check("flag_pulse", banderaConvertida, 0);
    end while (concedido == 0 && espera < 20);
    check("grant_onehot", concedido, 32'(1) << exp_k);
    check("grant_latency", espera, recien_fin ? 2 : 1);
    solicitud[exp_k] = 1'b0;
    ult = exp_k;
    v = (exp_k == 1) ? v1 : v0;
    mag   = int'(v);
    s_esp = 1'b0;
`ifdef CONVERSION_SIGNO_EN
    if (v[7]) begin
      mag   = 256 - int'(v);
      s_esp = 1'b1;
    end
`endif
    espera = 0;
    do begin
      @(negedge reloj);
      espera++;
      if (espera == 1) check("grant_pulse", concedido, 0);
    end while (!banderaConvertida && espera < 20);
    check("flag_latency", espera, ANCHO_BIN);
    check("bcd", bcd, bcd_ref(mag));
    check("id", idResultado, exp_k);
    check("signo", signo, s_esp);
    ultimo_bcd = bcd_ref(mag);
    recien_fin = 1'b1;
  endtask

  task automatic reset_mid;
    int espera;
    solicitud   = 2'b01;
    datoEntrada = {8'd0, 8'd200};
    espera = 0;
    do begin
      @(negedge reloj);
      espera++;
    end while (concedido == 0 && espera < 20);
    check("rst_pre_grant", concedido, 2'b01);
    solicitud = '0;
    repeat (3) @(negedge reloj);
    #2 reinicio = 1'b1;
    #1;
    check("rst_concedido", concedido, 0);
    check("rst_bcd", bcd, 0);
    check("rst_id", idResultado, 0);
    check("rst_flag", banderaConvertida, 0);
    check("rst_signo", signo, 0);
    @(negedge reloj);
    reinicio = 1'b0;
    ult = NSOL - 1;
    idle(12);
  endtask

  initial begin
    reinicio    = 1'b1;
    solicitud   = '0;
    datoEntrada = '0;
    ult         = NSOL - 1;
    recien_fin  = 1'b0;
    ultimo_bcd  = '0;
    repeat (2) @(negedge reloj);
    check("reset_concedido", concedido, 0);
    check("reset_bcd", bcd, 0);
    check("reset_id", idResultado, 0);
    check("reset_flag", banderaConvertida, 0);
    check("reset_signo", signo, 0);
    reinicio = 1'b0;
    idle(2);

    // Simultaneous requests from reset, then the held loser and back to 0.
    convertir(2'b11, 8'd42, 8'd7);
    convertir(2'b10, 8'd0, 8'd7);
    convertir(2'b01, 8'd255, 8'd0);
    // Continuous requests on both: order must alternate.
    for (int i = 0; i < 4; i++) convertir(2'b11, 8'(10 + i), 8'(200 + i));
    idle(3);

    begin
      logic [7:0] vals [8];
      vals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'hFF, 8'h80, 8'h7F};
      for (int i = 0; i < 8; i++) begin
        convertir((i % 2 == 0) ? 2'b01 : 2'b10, vals[i], vals[i]);
        idle(1);
      end
    end

    convertir(2'b10, 8'd0, 8'd77);
    reset_mid();

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      convertir(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom));
    end

    idle(5);
    check("bcd_hold", bcd, ultimo_bcd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
